// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the 9-bit display SPI link
// Purpose: default word geometry, idle pin levels and DC flag encodings
//          used by the SPI receive path.
// Ports:   none (package).
package spi_pkg;

  localparam int DEF_DATA_SIZE = 9;
  localparam int PAYLOAD_BITS  = 8;
  localparam int DC_BIT        = DEF_DATA_SIZE - 1;

  // Levels the pins rest at while the link is idle; synchronizers reset to these
  // so that reset release never looks like an edge.
  localparam logic SCK_IDLE = 1'b0;
  localparam logic CS_IDLE  = 1'b1;
  localparam logic DC_IDLE  = 1'b1;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detection
// Purpose: brings one asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset (flops take RESET_VAL)
//   din_i   in   asynchronous pin
//   level_o out  synchronized level
//   rise_o  out  one-clk pulse on a synchronized 0->1 transition
//   fall_o  out  one-clk pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~dly_q;
  assign fall_o  = ~level_o & dly_q;

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - oversampling receive end of the 9-bit display SPI link
// Purpose: oversamples spi_sck/mosi/dc/cs in the clk domain, rebuilds each
//          word as {dc, payload} MSB first, and holds it on a valid/ready port.
// Optional build macro: SPI_SLAVE_FRAME_ERR_EN enables aborted-frame detection.
// Ports:
//   clk       in   system clock (>= 4x spi_sck)
//   rst       in   asynchronous active-low reset
//   spi_sck   in   SPI clock, data sampled on rising edge
//   spi_mosi  in   serial data, MSB first
//   spi_dc    in   data/command flag, sampled with the last bit
//   spi_cs    in   chip select, active low
//   rx_data   out  received word {dc, payload}
//   rx_valid  out  rx_data holds an unread word
//   rx_ready  in   consumer accepts when rx_valid & rx_ready
//   overrun   out  one-clk pulse when a completed word is dropped
//   frame_err out  one-clk pulse when cs rises mid-word (0 when compiled out)
//   busy      out  synchronized chip select is active
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  input  logic                 spi_dc,
  input  logic                 spi_cs,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int PL    = DATA_SIZE - 1;
  localparam int CNT_W = $clog2(PL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PL - 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic dc_s, dc_rise, dc_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sck (
    .clk(clk), .rst_n(rst), .din_i(spi_sck),
    .level_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_cs (
    .clk(clk), .rst_n(rst), .din_i(spi_cs),
    .level_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst), .din_i(spi_mosi),
    .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(DC_IDLE)) u_dc (
    .clk(clk), .rst_n(rst), .din_i(spi_dc),
    .level_o(dc_s), .rise_o(dc_rise), .fall_o(dc_fall)
  );

  // Edge flags not needed on this path; the sck level itself is only used
  // through its rise pulse.
  logic unused_edges;
  assign unused_edges = ^{sck_s, sck_fall, cs_fall, mosi_rise, mosi_fall, dc_rise, dc_fall};

  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PL-1:0]        shift_q, shift_d;
  logic [DATA_SIZE-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 capture;
  logic                 handshake;
  logic [DATA_SIZE-1:0] word;

  // The last bit goes straight into the word from the synchronizer, so the
  // capture does not wait for the shift register to update.
  assign word      = {dc_s, shift_q[PL-2:0], mosi_s};
  assign handshake = rx_valid_q & rx_ready;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    capture    = 1'b0;

    if (cs_rise) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (sck_rise && !cs_s) begin
      shift_d = {shift_q[PL-2:0], mosi_s};
      if (bit_cnt_q == CNT_LAST) begin
        bit_cnt_d = '0;
        capture   = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    // A handshake in the capture cycle frees the register, so the new word
    // replaces the consumed one without a drop.
    if (capture) begin
      if (!rx_valid_q || handshake) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= cs_rise && (bit_cnt_q != '0);
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = ~cs_s;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - self-checking bench for spi_slave_rx
module tb_spi_slave_rx;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam int FE_EN = 1;
`else
  localparam int FE_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_dc = 1'b1;
  logic       spi_cs = 1'b1;
  logic       rx_ready = 1'b0;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  spi_slave_rx dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_cs(spi_cs),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int valid_hi = 0;
  int t_last = 0;
  int t_valid = 0;
  int fe_exp = 0;
  logic valid_prev = 1'b0;
  int got_q[$];
  int exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records every accepted word and counts status pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) got_q.push_back(int'(rx_data));
      if (overrun) ovr_cnt++;
      if (frame_err) fe_cnt++;
      if (rx_valid) valid_hi++;
      if (rx_valid && !valid_prev) t_valid = cyc;
    end
    valid_prev = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of a 9-bit word, sck at clk/4. With pulse set,
  // rx_ready is raised for exactly the cycle in which the word is captured.
  task automatic send(input int word, input int nbits, input bit pulse);
    spi_dc = word[8];
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = word[7-i];
      spi_sck  = 1'b0;
      tick(2);
      spi_sck = 1'b1;
      if (i == 7) t_last = cyc;
      tick(2);
    end
    spi_sck = 1'b0;
    if (pulse) begin
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
    end
  endtask

  task automatic frame_begin();
    spi_cs = 1'b0;
    tick(3);
  endtask

  task automatic frame_end();
    spi_sck = 1'b0;
    tick(2);
    spi_cs = 1'b1;
    tick(6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0, fe0, vh0, nw, w, nb;

    // Reset state
    tick(3);
    check("rst_data", int'(rx_data), 0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_fe", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick(3);

    // Single data word with latency and valid width
    rx_ready = 1'b1;
    vh0 = valid_hi;
    frame_begin();
    check("busy_on", int'(busy), 1);
    send(9'h1A5, 8, 1'b0);
    exp_q.push_back(9'h1A5);
    frame_end();
    check("busy_off", int'(busy), 0);
    check("latency", t_valid - t_last, 3);
    check("valid_width", valid_hi - vh0, 1);
    check("t1_ovr", ovr_cnt, 0);
    check("t1_fe", fe_cnt, 0);

    // Command then data, back-to-back
    frame_begin();
    send(9'h02A, 8, 1'b0);
    send(9'h100, 8, 1'b0);
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'h100);
    frame_end();

    // Overrun
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    frame_begin();
    send(9'h155, 8, 1'b0);
    send(9'h0FF, 8, 1'b0);
    frame_end();
    check("ovr_data", int'(rx_data), 9'h155);
    check("ovr_valid", int'(rx_valid), 1);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    exp_q.push_back(9'h155);
    tick(1);
    check("ovr_drain_valid", int'(rx_valid), 0);
    check("ovr_hold_data", int'(rx_data), 9'h155);

    // Aborted frame
    rx_ready = 1'b1;
    fe0 = fe_cnt;
    frame_begin();
    send(9'h1F0, 5, 1'b0);
    frame_end();
    check("abort_fe", fe_cnt - fe0, FE_EN);
    frame_begin();
    send(9'h133, 8, 1'b0);
    exp_q.push_back(9'h133);
    frame_end();

    // Reset mid-word with a pending word
    rx_ready = 1'b0;
    frame_begin();
    send(9'h0AB, 8, 1'b0);
    send(9'h1FF, 4, 1'b0);
    check("pre_rst_valid", int'(rx_valid), 1);
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b0;
    #2;
    check("async_rst_data", int'(rx_data), 0);
    check("async_rst_valid", int'(rx_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ovr", int'(overrun), 0);
    spi_cs = 1'b1;
    spi_sck = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    check("post_rst_valid", int'(rx_valid), 0);
    rx_ready = 1'b1;
    frame_begin();
    send(9'h0C3, 8, 1'b0);
    exp_q.push_back(9'h0C3);
    frame_end();

    // Handshake in the capture cycle
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    frame_begin();
    send(9'h111, 8, 1'b0);
    send(9'h122, 8, 1'b1);
    exp_q.push_back(9'h111);
    frame_end();
    check("simul_data", int'(rx_data), 9'h122);
    check("simul_valid", int'(rx_valid), 1);
    check("simul_ovr", ovr_cnt - ovr0, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    exp_q.push_back(9'h122);
    tick(1);
    check("simul_drain", int'(rx_valid), 0);

    // Randomized frames, occasionally ending in an aborted partial word
    rx_ready = 1'b1;
    fe0 = fe_cnt;
    fe_exp = 0;
    for (int f = 0; f < 12; f++) begin
      nw = $urandom_range(1, 3);
      frame_begin();
      for (int k = 0; k < nw; k++) begin
        w = $urandom_range(0, 511);
        send(w, 8, 1'b0);
        exp_q.push_back(w);
      end
      if ($urandom_range(0, 2) == 0) begin
        nb = $urandom_range(1, 7);
        send($urandom_range(0, 511), nb, 1'b0);
        fe_exp++;
      end
      frame_end();
      tick($urandom_range(0, 5));
    end
    check("rand_fe", fe_cnt - fe0, fe_exp * FE_EN);
    check("total_ovr", ovr_cnt, 1);

    // Scoreboard
    check("word_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("word%0d", i), got_q[i], exp_q[i]);
      else check($sformatf("word%0d_missing", i), -1, exp_q[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive end of the team's 9-bit display SPI link (spi_sck, spi_mosi, spi_dc, spi_cs).
- Oversamples the four SPI pins in the system clock domain.
- Rebuilds each word as {dc, data[7:0]}, MSB first, and presents it on a valid/ready handshake.
- Used as a display-side model in benches and as a loopback/monitor block on-chip.

Parameters:
- DATA_SIZE, 9: received word width; bit DATA_SIZE-1 is DC and bits DATA_SIZE-2..0 are the payload.
- SYNC_STAGES, 2: synchronizer flops per SPI input; legal range 2..3.

Ports:
- clk  input  1  system clock; must be at least 4x the spi_sck frequency, with sck high and low phases each at least 2 clk.
- rst  input  1  asynchronous, active-low reset.
- spi_sck  input  1  SPI clock; idle low while spi_cs is high; data sampled on rising edge.
- spi_mosi  input  1  serial data, MSB first.
- spi_dc  input  1  data/command flag; 1 = data, 0 = command.
- spi_cs  input  1  chip select, active low.
- rx_data  output  DATA_SIZE  received word {dc, payload}.
- rx_valid  output  1  rx_data holds an unread word.
- rx_ready  input  1  consumer accepts the word when rx_valid and rx_ready are both high.
- overrun  output  1  one-clk pulse when a completed word is dropped.
- frame_err  output  1  one-clk pulse on an aborted frame (optional feature; tied 0 when the feature is compiled out).
- busy  output  1  high while spi_cs is low after synchronization.

Behaviour:
- Reset (rst low, asynchronous):
  - Synchronizers take the idle pattern: sck=0, cs=1, mosi=0, dc=1.
  - rx_data = 0, rx_valid = 0, overrun = 0, frame_err = 0, busy = 0, bit_cnt = 0, shift = 0.
  - Reset asserted mid-word discards the partial word; nothing is emitted after release.
- Synchronization and edge detection:
  - Each SPI input passes through SYNC_STAGES flops.
  - Rising sck is detected when synchronized sck = 1 and its one-clk-delayed copy = 0.
  - A rising sck is acted on only while synchronized cs = 0.
- Shifting on each qualified rising sck:
  - shift <= {shift[6:0], mosi_s}; bit_cnt increments by 1.
  - On the 8th bit (bit_cnt == 7): capture word = {dc_s, shift[6:0], mosi_s}, then bit_cnt wraps to 0.
  - DC is sampled only on the 8th bit.
- Latency (SYNC_STAGES = 2): rx_valid is high after the 3rd clk rising edge, counting as edge 1 the first clk edge that samples the 8th spi_sck high.
- Output register:
  - On word capture with rx_valid = 0: rx_data <= word, rx_valid <= 1.
  - On word capture with rx_valid = 1 and no handshake in the same cycle: word is dropped, overrun pulses for 1 clk, rx_data is unchanged.
  - Handshake (rx_valid & rx_ready) in the same cycle as a capture: the new word is loaded and rx_valid stays 1 (no overrun).
  - Handshake with no capture: rx_valid <= 0; rx_data holds its value.
- Chip-select deassert (synchronized cs rises): bit_cnt <= 0 and shift is cleared. A partial word (bit_cnt != 0) is discarded and never emitted.
- Back-to-back words with cs held low are supported; bit_cnt wraps every 8 bits.
- busy equals the inverse of synchronized cs.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- Defined: frame_err pulses for 1 clk when synchronized cs rises while bit_cnt != 0. The same clk also clears bit_cnt.
- Not defined: frame_err is constant 0 and no detection logic is built. All other behaviour is identical.

Decomposition:
- Shared package spi_pkg holds:
  - DATA_SIZE default (9), DC_BIT index, PAYLOAD_BITS (8).
  - Idle pin levels: SCK_IDLE = 0, CS_IDLE = 1, DC_IDLE = 1.
  - DC_CMD = 0 and DC_DATA = 1.
- One sub-module, spi_sync_edge: SYNC_STAGES flop synchronizer plus a delayed copy. Outputs are the level, rise pulse and fall pulse.
  - Instantiated for sck (level + rise) and for cs (level + rise).
  - mosi and dc use the level output only.

Test Plan:
- Single data word, clk = 4x sck: send dc=1, payload 0xA5 with rx_ready = 1 -> rx_data = 0x1A5 with a 1-clk rx_valid; overrun = 0; frame_err = 0.
- Command then data, back-to-back with cs held low: send {0, 0x2A} then {1, 0x00}, with rx_ready = 1 -> words 0x02A then 0x100 in order, no drops.
- Overrun: rx_ready = 0, send 0x155 then 0x0FF -> rx_data stays 0x155 with rx_valid high; overrun pulses once after the 2nd word. Raising rx_ready then gives one handshake, and rx_valid drops.
- Aborted frame: send 5 bits of 0x1F0, raise cs, then send a full 0x133 -> only 0x133 is delivered. With SPI_SLAVE_FRAME_ERR_EN, frame_err pulses once at the cs rise; without it, frame_err stays 0.
- Reset mid-word: assert rst after 4 bits -> all outputs return to 0 immediately (asynchronously). After release, a full word 0x0C3 is received correctly.
- Simultaneous handshake and capture: hold rx_valid with 0x111, pulse rx_ready exactly on the capture cycle of 0x122 -> rx_data = 0x122, rx_valid stays 1, no overrun.
